galvo_position_stepper: RTL and testbench

//  Galvo mirror driver downstream of the acquisition sequencer. Each rising edge of the

---
 rtl/galvo_position_stepper_if.sv | 37 +++
 rtl/galvo_position_stepper.sv | 239 +++++++++++++++++++++++
 tb/tb_galvo_position_stepper.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/galvo_position_stepper_if.sv
// Sequencer-side bundle of the galvo position stepper: trigger/restart
// handshake, scan geometry, settle time, status and the SPI DAC pins.
interface galvo_position_stepper_if;
  logic        iTRIGGER;
  logic        iRESTART;
  logic [15:0] iX_START;
  logic [15:0] iX_STEP;
  logic [15:0] iNUM_X;
  logic [15:0] iY_START;
  logic [15:0] iY_STEP;
  logic [15:0] iNUM_Y;
  logic [15:0] iSETTLE_US;
  logic        oACK;
  logic        oBUSY;
  logic        oOVERRUN;
  logic [15:0] oX_IDX;
  logic [15:0] oY_IDX;
  logic        oDAC_CS_N;
  logic        oDAC_SCLK;
  logic        oDAC_MOSI;

  // Sequencer / bench side
  modport master (
    output iTRIGGER, iRESTART, iX_START, iX_STEP, iNUM_X,
           iY_START, iY_STEP, iNUM_Y, iSETTLE_US,
    input  oACK, oBUSY, oOVERRUN, oX_IDX, oY_IDX,
           oDAC_CS_N, oDAC_SCLK, oDAC_MOSI
  );

  // Stepper side
  modport slave (
    input  iTRIGGER, iRESTART, iX_START, iX_STEP, iNUM_X,
           iY_START, iY_STEP, iNUM_Y, iSETTLE_US,
    output oACK, oBUSY, oOVERRUN, oX_IDX, oY_IDX,
           oDAC_CS_N, oDAC_SCLK, oDAC_MOSI
  );
endinterface

// File: rtl/galvo_position_stepper.sv
// Galvo position stepper: on each synchronised trigger edge, writes the next
// raster X/Y DAC code pair over a mode-0 SPI link, waits the settle time and
// returns a one-cycle acknowledge to the acquisition sequencer.
module galvo_position_stepper #(
  parameter int SPI_DIV  = 4,
  parameter int US_TICKS = 50
) (
  input logic                  iCLK,
  input logic                  iRST_N,
  galvo_position_stepper_if.slave bus
);

  localparam int              DIV_W    = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);
  localparam logic [4:0]      LAST_BIT = 5'd23;
  localparam logic [7:0]      CMD_X    = 8'h30;
  localparam logic [7:0]      CMD_Y    = 8'h31;

  typedef enum logic [2:0] {
    IDLE, LOAD, SPI_X, GAP, SPI_Y, SETTLE, ACK, ADVANCE
  } state_t;

  // Settle length in clocks; a zero request still waits one clock.
  function automatic logic [31:0] settle_ticks(input logic [15:0] us);
    logic [31:0] prod;
    prod = 32'(us) * 32'(US_TICKS);
    return (prod == 32'd0) ? 32'd1 : prod;
  endfunction

  // Zero-length scan dimensions behave as a single column/row.
  function automatic logic [15:0] at_least_one(input logic [15:0] n);
    return (n == 16'd0) ? 16'd1 : n;
  endfunction

  state_t            state, state_next;

  logic              trig_s1, trig_s2, trig_d, edge_seen;

  logic [15:0]       x_idx, y_idx;
  logic [15:0]       x_code, y_code;
  logic [15:0]       x_idx_out, y_idx_out;
  logic              overrun;
  logic              restart_pend;
  logic              restart_req;
  logic              x_last, y_last;

  logic [DIV_W-1:0]  div_cnt;
  logic              half_hi;
  logic [4:0]        bit_cnt;
  logic              sclk;
  logic              spi_active;
  logic              div_end;
  logic              frame_done;
  logic              gap_cnt;
  logic [31:0]       settle_cnt;

  logic [23:0]       shreg;
  logic [15:0]       y_word;

  logic              ack, busy, cs_n;

  assign spi_active  = (state == SPI_X) || (state == SPI_Y);
  assign div_end     = (div_cnt == DIV_LAST);
  assign frame_done  = spi_active && half_hi && div_end && (bit_cnt == LAST_BIT);
  assign restart_req = bus.iRESTART || restart_pend;
  assign x_last      = ({1'b0, x_idx} + 17'd1) >= {1'b0, at_least_one(bus.iNUM_X)};
  assign y_last      = ({1'b0, y_idx} + 17'd1) >= {1'b0, at_least_one(bus.iNUM_Y)};

  // Two-flop synchroniser followed by a registered rising-edge detect.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_d    <= 1'b0;
      edge_seen <= 1'b0;
    end else begin
      trig_s1   <= bus.iTRIGGER;
      trig_s2   <= trig_s1;
      trig_d    <= trig_s2;
      edge_seen <= trig_s2 && !trig_d;
    end
  end

  // Sequencer state register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and decoded control outputs.
  always_comb begin
    state_next = state;
    ack        = 1'b0;
    busy       = 1'b1;
    cs_n       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (edge_seen) state_next = LOAD;
      end
      LOAD:    state_next = SPI_X;
      SPI_X: begin
        cs_n = 1'b0;
        if (frame_done) state_next = GAP;
      end
      GAP:     if (gap_cnt) state_next = SPI_Y;
      SPI_Y: begin
        cs_n = 1'b0;
        if (frame_done) state_next = SETTLE;
      end
      SETTLE:  if (settle_cnt == 32'd0) state_next = ACK;
      ACK: begin
        ack        = 1'b1;
        state_next = ADVANCE;
      end
      // An edge landing while we hand back to IDLE is taken, not dropped.
      ADVANCE: state_next = edge_seen ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Scan index/code bookkeeping, restart handling and the overrun flag.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x_idx        <= '0;
      y_idx        <= '0;
      x_code       <= '0;
      y_code       <= '0;
      x_idx_out    <= '0;
      y_idx_out    <= '0;
      overrun      <= 1'b0;
      restart_pend <= 1'b0;
    end else begin
      if (state == IDLE) begin
        restart_pend <= 1'b0;
        if (bus.iRESTART) begin
          x_idx   <= '0;
          y_idx   <= '0;
          x_code  <= bus.iX_START;
          y_code  <= bus.iY_START;
          overrun <= 1'b0;
        end
      end else if (state == ADVANCE) begin
        restart_pend <= 1'b0;
        if (restart_req) begin
          x_idx   <= '0;
          y_idx   <= '0;
          x_code  <= bus.iX_START;
          y_code  <= bus.iY_START;
          overrun <= 1'b0;
        end else if (!x_last) begin
          x_idx  <= x_idx + 16'd1;
          x_code <= x_code + bus.iX_STEP;
        end else begin
          x_idx  <= '0;
          x_code <= bus.iX_START;
          if (!y_last) begin
            y_idx  <= y_idx + 16'd1;
            y_code <= y_code + bus.iY_STEP;
          end else begin
            y_idx  <= '0;
            y_code <= bus.iY_START;
          end
        end
      end else if (bus.iRESTART) begin
        restart_pend <= 1'b1;
      end

      // A trigger edge while mid-update cannot be honoured; flag it.
      if (edge_seen && (state != IDLE) && (state != ADVANCE)) overrun <= 1'b1;

      if (state == LOAD) begin
        x_idx_out <= x_idx;
        y_idx_out <= y_idx;
      end
    end
  end

  // SPI bit timing, the inter-frame gap and the settle countdown.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      div_cnt    <= '0;
      half_hi    <= 1'b0;
      bit_cnt    <= '0;
      sclk       <= 1'b0;
      gap_cnt    <= 1'b0;
      settle_cnt <= '0;
    end else begin
      if (!spi_active) begin
        div_cnt <= '0;
        half_hi <= 1'b0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
      end else if (div_end) begin
        div_cnt <= '0;
        if (!half_hi) begin
          half_hi <= 1'b1;
          sclk    <= 1'b1;
        end else begin
          half_hi <= 1'b0;
          sclk    <= 1'b0;
          bit_cnt <= bit_cnt + 5'd1;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      gap_cnt <= (state == GAP) && !gap_cnt;

      if ((state == SPI_Y) && frame_done)
        settle_cnt <= settle_ticks(bus.iSETTLE_US) - 32'd1;
      else if ((state == SETTLE) && (settle_cnt != 32'd0))
        settle_cnt <= settle_cnt - 32'd1;
    end
  end

  // Frame shift register: X word loaded in LOAD, Y word at the end of the
  // gap; shifts on each SCLK fall so MOSI only moves while SCLK is low.
  always_ff @(posedge iCLK) begin
    if (state == LOAD) begin
      shreg  <= {CMD_X, x_code};
      y_word <= y_code;
    end else if ((state == GAP) && gap_cnt) begin
      shreg  <= {CMD_Y, y_word};
    end else if (spi_active && div_end && half_hi) begin
      shreg  <= {shreg[22:0], 1'b0};
    end
  end

  assign bus.oACK      = ack;
  assign bus.oBUSY     = busy;
  assign bus.oOVERRUN  = overrun;
  assign bus.oX_IDX    = x_idx_out;
  assign bus.oY_IDX    = y_idx_out;
  assign bus.oDAC_CS_N = cs_n;
  assign bus.oDAC_SCLK = sclk;
  assign bus.oDAC_MOSI = spi_active && shreg[23];

endmodule

// File: tb/tb_galvo_position_stepper.sv
// Directed bench for galvo_position_stepper: decodes the SPI words, measures
// trigger-to-ack latency and checks index stepping, overrun and reset abort.
module tb_galvo_position_stepper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acks = 0;
  int   sclk_rises = 0;
  int   bitcnt = 0;
  int   nwords = 0;
  logic [23:0] sh_word = '0;
  logic [23:0] wordlog [256];

  galvo_position_stepper_if bus();

  galvo_position_stepper #(.SPI_DIV(4), .US_TICKS(50)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.oACK) acks <= acks + 1;
  end

  // Capture SPI words: CS falling starts a frame, SCLK rising samples MOSI.
  always @(posedge bus.oDAC_SCLK or negedge bus.oDAC_CS_N) begin
    if (bus.oDAC_SCLK) begin
      sclk_rises = sclk_rises + 1;
      if (!bus.oDAC_CS_N) begin
        sh_word = {sh_word[22:0], bus.oDAC_MOSI};
        bitcnt  = bitcnt + 1;
        if (bitcnt == 24) begin
          wordlog[nwords % 256] = sh_word;
          nwords = nwords + 1;
          bitcnt = 0;
        end
      end
    end else begin
      bitcnt = 0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic restart_pulse();
    @(negedge clk) bus.iRESTART = 1'b1;
    @(negedge clk) bus.iRESTART = 1'b0;
    @(negedge clk);
  endtask

  // Raise the trigger, optionally re-raise it at cycle retrig_at, and wait
  // for the acknowledge. lat is clocks from the first edge sampling high.
  task automatic run_trig(input int retrig_at, output int lat, output bit got);
    int t0;
    got = 1'b0;
    lat = -1;
    @(negedge clk);
    bus.iTRIGGER = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) bus.iTRIGGER = 1'b0;
      if (retrig_at >= 0 && i == retrig_at) bus.iTRIGGER = 1'b1;
      if (retrig_at >= 0 && i == retrig_at + 20) bus.iTRIGGER = 1'b0;
      if (bus.oACK) begin
        got = 1'b1;
        lat = cyc - t0 - 1;
        break;
      end
    end
    bus.iTRIGGER = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int n0, input logic [15:0] xc,
                             input logic [15:0] yc, input logic [15:0] xi, input logic [15:0] yi);
    check({tag, "_nwords"}, 32'(nwords - n0), 32'd2);
    check({tag, "_xword"}, {8'h0, wordlog[n0 % 256]}, {8'h0, 8'h30, xc});
    check({tag, "_yword"}, {8'h0, wordlog[(n0 + 1) % 256]}, {8'h0, 8'h31, yc});
    check({tag, "_xidx"}, {16'h0, bus.oX_IDX}, {16'h0, xi});
    check({tag, "_yidx"}, {16'h0, bus.oY_IDX}, {16'h0, yi});
  endtask

  initial begin
    int lat;
    bit got;
    int n0, r0, a0;
    logic [15:0] exp_x [7];
    logic [15:0] exp_y [7];
    logic [15:0] exp_xi [7];
    logic [15:0] exp_yi [7];

    exp_x  = '{16'h1000, 16'h1100, 16'h1200, 16'h1000, 16'h1100, 16'h1200, 16'h1000};
    exp_y  = '{16'h2000, 16'h2000, 16'h2000, 16'h2200, 16'h2200, 16'h2200, 16'h2000};
    exp_xi = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0};
    exp_yi = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd0};

    bus.iTRIGGER   = 1'b0;
    bus.iRESTART   = 1'b0;
    bus.iX_START   = 16'h1000;
    bus.iX_STEP    = 16'h0100;
    bus.iNUM_X     = 16'd3;
    bus.iY_START   = 16'h2000;
    bus.iY_STEP    = 16'h0200;
    bus.iNUM_Y     = 16'd2;
    bus.iSETTLE_US = 16'd2;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",     32'(bus.oACK), 32'd0);
    check("rst_busy",    32'(bus.oBUSY), 32'd0);
    check("rst_overrun", 32'(bus.oOVERRUN), 32'd0);
    check("rst_xidx",    32'(bus.oX_IDX), 32'd0);
    check("rst_yidx",    32'(bus.oY_IDX), 32'd0);
    check("rst_cs_n",    32'(bus.oDAC_CS_N), 32'd1);
    check("rst_sclk",    32'(bus.oDAC_SCLK), 32'd0);
    check("rst_mosi",    32'(bus.oDAC_MOSI), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    restart_pulse();

    // First position: latency with 2 us settle and full SPI bit count
    n0 = nwords;
    r0 = sclk_rises;
    run_trig(-1, lat, got);
    check("t3_ack_seen", 32'(got), 32'd1);
    check("t3_latency", 32'(lat), 32'd490);
    check("t3_sclk_rises", 32'(sclk_rises - r0), 32'd48);
    check_frame("t3", n0, exp_x[0], exp_y[0], exp_xi[0], exp_yi[0]);
    repeat (3) @(posedge clk);
    #1;
    check("t3_idle_busy", 32'(bus.oBUSY), 32'd0);

    // Raster stepping with zero settle
    bus.iSETTLE_US = 16'd0;
    for (int k = 1; k < 7; k++) begin
      n0 = nwords;
      run_trig(-1, lat, got);
      check($sformatf("t2_ack_seen%0d", k), 32'(got), 32'd1);
      check($sformatf("t2_latency%0d", k), 32'(lat), 32'd391);
      check_frame($sformatf("t2_pos%0d", k), n0, exp_x[k], exp_y[k], exp_xi[k], exp_yi[k]);
      repeat (3) @(posedge clk);
    end

    // Overrun: second edge during SETTLE is dropped
    bus.iSETTLE_US = 16'd2;
    a0 = acks;
    n0 = nwords;
    run_trig(420, lat, got);
    check("t4_latency", 32'(lat), 32'd490);
    check_frame("t4", n0, 16'h1100, 16'h2000, 16'd1, 16'd0);
    repeat (600) @(posedge clk);
    #1;
    check("t4_single_ack", 32'(acks - a0), 32'd1);
    check("t4_overrun_set", 32'(bus.oOVERRUN), 32'd1);
    check("t4_idle_busy", 32'(bus.oBUSY), 32'd0);
    restart_pulse();
    check("t4_overrun_clr", 32'(bus.oOVERRUN), 32'd0);

    // Reset in the middle of the Y frame aborts it at once
    @(negedge clk) bus.iTRIGGER = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.iTRIGGER = 1'b0;
    repeat (240) @(posedge clk);
    #1;
    check("t1_in_frame_cs_n", 32'(bus.oDAC_CS_N), 32'd0);
    check("t1_in_frame_busy", 32'(bus.oBUSY), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t1_abort_cs_n", 32'(bus.oDAC_CS_N), 32'd1);
    check("t1_abort_sclk", 32'(bus.oDAC_SCLK), 32'd0);
    check("t1_abort_busy", 32'(bus.oBUSY), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check("t1_post_xidx", 32'(bus.oX_IDX), 32'd0);
    restart_pulse();
    n0 = nwords;
    run_trig(-1, lat, got);
    check("t1_ack_seen", 32'(got), 32'd1);
    check_frame("t1", n0, 16'h1000, 16'h2000, 16'd0, 16'd0);
    repeat (3) @(posedge clk);

    // Code wrap modulo 2^16, zero settle, NUM_Y of zero acts as one row
    bus.iX_START   = 16'hFF80;
    bus.iX_STEP    = 16'h0100;
    bus.iNUM_X     = 16'd2;
    bus.iY_START   = 16'h0ABC;
    bus.iY_STEP    = 16'h0010;
    bus.iNUM_Y     = 16'd0;
    bus.iSETTLE_US = 16'd0;
    restart_pulse();
    n0 = nwords;
    run_trig(-1, lat, got);
    check("t5_latency", 32'(lat), 32'd391);
    check_frame("t5_p0", n0, 16'hFF80, 16'h0ABC, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    n0 = nwords;
    run_trig(-1, lat, got);
    check_frame("t5_p1", n0, 16'h0080, 16'h0ABC, 16'd1, 16'd0);
    repeat (3) @(posedge clk);
    n0 = nwords;
    run_trig(-1, lat, got);
    check_frame("t5_p2", n0, 16'hFF80, 16'h0ABC, 16'd0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
